custom_wb_stage: RTL and testbench

Result/writeback stage directly downstream of the custom execute stage. It captures each completed custom-instruction result (destination register address, 32-bit value, instruction ID) into a small FIFO. It then presents the results in order on the core's X-interface result channel with a valid/ready handshake, absorbing back-pressure from the core so the execute stage never has to stall mid-computation.

---
 rtl/custom_wb_stage.sv | 127 ++++++++++++
 tb/tb_custom_wb_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/custom_wb_stage.sv
// Writeback stage for custom-instruction results: a small in-order FIFO
// feeding the X-interface result channel. Optional same-cycle bypass: CUSTOM_WB_BYPASS_EN.
`timescale 1ns/1ps
module custom_wb_stage #(
   parameter int DEPTH    = 2,
   parameter int ID_WIDTH = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                ex_valid_i,
   input  logic [31:0]         ex_data_i,
   input  logic [4:0]          ex_rd_addr_i,
   input  logic [ID_WIDTH-1:0] ex_id_i,
   output logic                ex_ready_o,
   output logic                result_valid_o,
   input  logic                result_ready_i,
   output logic [31:0]         result_data_o,
   output logic [4:0]          result_rd_o,
   output logic [ID_WIDTH-1:0] result_id_o,
   output logic                result_we_o,
   output logic                overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]         data_q [DEPTH];
   logic [31:0]         data_d [DEPTH];
   logic [4:0]          rd_q   [DEPTH];
   logic [4:0]          rd_d   [DEPTH];
   logic [ID_WIDTH-1:0] id_q   [DEPTH];
   logic [ID_WIDTH-1:0] id_d   [DEPTH];
   logic [AW-1:0]       wptr_q, wptr_d;
   logic [AW-1:0]       rptr_q, rptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic                overflow_q, overflow_d;

   logic fifo_valid;
   logic full;
   logic handshake;
   logic fifo_pop;
   logic push;
   logic drop;

   assign fifo_valid = (count_q != '0);
   assign full       = (count_q == CW'(DEPTH));

   // Result channel normally shows the FIFO head; bypass shows the incoming result when empty.
   always_comb begin
      result_valid_o = fifo_valid;
      result_data_o  = data_q[rptr_q];
      result_rd_o    = rd_q[rptr_q];
      result_id_o    = id_q[rptr_q];
`ifdef CUSTOM_WB_BYPASS_EN
      if (!fifo_valid && ex_valid_i) begin
         result_valid_o = 1'b1;
         result_data_o  = ex_data_i;
         result_rd_o    = ex_rd_addr_i;
         result_id_o    = ex_id_i;
      end
`endif
   end

   assign handshake   = result_valid_o && result_ready_i;
   assign fifo_pop    = fifo_valid && handshake;
   assign ex_ready_o  = !full || handshake;
   assign result_we_o = result_valid_o && (result_rd_o != 5'd0);
   assign overflow_o  = overflow_q;

`ifdef CUSTOM_WB_BYPASS_EN
   // A bypassed result accepted in the same cycle never touches storage.
   assign push = ex_valid_i && ex_ready_o && !(!fifo_valid && handshake);
`else
   assign push = ex_valid_i && ex_ready_o;
`endif
   assign drop = ex_valid_i && !ex_ready_o;

   always_comb begin
      data_d     = data_q;
      rd_d       = rd_q;
      id_d       = id_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push) begin
         data_d[wptr_q] = ex_data_i;
         rd_d[wptr_q]   = ex_rd_addr_i;
         id_d[wptr_q]   = ex_id_i;
         wptr_d         = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (fifo_pop) begin
         rptr_d = (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      end
      if (push && !fifo_pop) begin
         count_d = count_q + 1'b1;
      end else if (fifo_pop && !push) begin
         count_d = count_q - 1'b1;
      end
      if (drop) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            rd_q[i]   <= '0;
            id_q[i]   <= '0;
         end
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         data_q     <= data_d;
         rd_q       <= rd_d;
         id_q       <= id_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_custom_wb_stage.sv
// Scoreboard bench for custom_wb_stage (default build, no bypass).
`timescale 1ns/1ps
module tb_custom_wb_stage;

   localparam int DEPTH    = 2;
   localparam int ID_WIDTH = 4;

   typedef struct {
      logic [31:0]         data;
      logic [4:0]          rd;
      logic [ID_WIDTH-1:0] id;
   } item_t;

   logic                clk_i = 1'b0;
   logic                rst_i;
   logic                ex_valid_i;
   logic [31:0]         ex_data_i;
   logic [4:0]          ex_rd_addr_i;
   logic [ID_WIDTH-1:0] ex_id_i;
   logic                ex_ready_o;
   logic                result_valid_o;
   logic                result_ready_i;
   logic [31:0]         result_data_o;
   logic [4:0]          result_rd_o;
   logic [ID_WIDTH-1:0] result_id_o;
   logic                result_we_o;
   logic                overflow_o;

   // Reference model: the queue holds results accepted but not yet delivered
   item_t sb[$];
   bit    modelOverflow;
   int    tests = 0;
   int    fails = 0;

   custom_wb_stage #(.DEPTH(DEPTH), .ID_WIDTH(ID_WIDTH)) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .ex_valid_i(ex_valid_i),
      .ex_data_i(ex_data_i),
      .ex_rd_addr_i(ex_rd_addr_i),
      .ex_id_i(ex_id_i),
      .ex_ready_o(ex_ready_o),
      .result_valid_o(result_valid_o),
      .result_ready_i(result_ready_i),
      .result_data_o(result_data_o),
      .result_rd_o(result_rd_o),
      .result_id_o(result_id_o),
      .result_we_o(result_we_o),
      .overflow_o(overflow_o)
   );

   always #5 clk_i = ~clk_i;

   // One comparison: count it, report on mismatch
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs; decide acceptance from the model occupancy
   task automatic applyStimulus(input bit v, input logic [31:0] d, input logic [4:0] rd,
                                input logic [ID_WIDTH-1:0] id, input bit rdy);
      int    occ;
      bit    accept;
      item_t it;
      occ    = sb.size();
      accept = v && ((occ < DEPTH) || (occ > 0 && rdy));
      ex_valid_i     = v;
      ex_data_i      = d;
      ex_rd_addr_i   = rd;
      ex_id_i        = id;
      result_ready_i = rdy;
      it.data = d;
      it.rd   = rd;
      it.id   = id;
      @(posedge clk_i);
      if (accept) sb.push_back(it);
      else if (v) modelOverflow = 1'b1;
      #1;
      ex_valid_i = 1'b0;
   endtask

   // Hold reset two cycles, clear the model, then check the reset state
   task automatic doReset();
      rst_i      = 1'b1;
      ex_valid_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      sb.delete();
      modelOverflow = 1'b0;
      rst_i = 1'b0;
      checkOutput("rst_valid", result_valid_o, 0);
      checkOutput("rst_ex_ready", ex_ready_o, 1);
      checkOutput("rst_overflow", overflow_o, 0);
      checkOutput("rst_we", result_we_o, 0);
      checkOutput("rst_data", result_data_o, 0);
      checkOutput("rst_rd", result_rd_o, 0);
      checkOutput("rst_id", result_id_o, 0);
   endtask

   // Monitor: mid-cycle, compare the channel against the model head; pop on handshake
   always @(negedge clk_i) begin
      if (!rst_i) begin
         checkOutput("valid", result_valid_o, (sb.size() > 0));
         checkOutput("ex_ready", ex_ready_o, (sb.size() < DEPTH) || (sb.size() > 0 && result_ready_i));
         checkOutput("overflow", overflow_o, modelOverflow);
         if (sb.size() > 0 && result_valid_o) begin
            checkOutput("data", result_data_o, sb[0].data);
            checkOutput("rd", result_rd_o, sb[0].rd);
            checkOutput("id", result_id_o, sb[0].id);
            checkOutput("we", result_we_o, (sb[0].rd != 5'd0));
            if (result_ready_i) void'(sb.pop_front());
         end
      end
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_i          = 1'b1;
      ex_valid_i     = 1'b0;
      ex_data_i      = '0;
      ex_rd_addr_i   = '0;
      ex_id_i        = '0;
      result_ready_i = 1'b0;
      modelOverflow  = 1'b0;
      @(posedge clk_i);
      #1;
      doReset();
      repeat (2) applyStimulus(0, 0, 0, 0, 1);

      // Single result with ready held high
      applyStimulus(1, 32'h5, 5'd10, 4'd3, 1);
      repeat (2) applyStimulus(0, 0, 0, 0, 1);

      // Back-pressure: fill with A and B, then try C while full
      applyStimulus(1, 32'h8, 5'd1, 4'd1, 0);
      applyStimulus(1, 32'h3, 5'd2, 4'd2, 0);
      checkOutput("full_ex_ready", ex_ready_o, 0);
      repeat (2) applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(1, 32'h1, 5'd3, 4'd3, 0);
      checkOutput("overflow_set", overflow_o, 1);

      // Full with simultaneous push and pop: A leaves, D enters
      applyStimulus(1, 32'h7, 5'd4, 4'd4, 1);
      repeat (4) applyStimulus(0, 0, 0, 0, 1);
      checkOutput("overflow_sticky", overflow_o, 1);
      checkOutput("drained_1", sb.size(), 0);
      doReset();

      // x0 destination and pointer wrap with ready toggling
      begin
         logic [4:0] rdList [5];
         rdList[0] = 5'd5;
         rdList[1] = 5'd0;
         rdList[2] = 5'd7;
         rdList[3] = 5'd9;
         rdList[4] = 5'd0;
         for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 32'h100 + i, rdList[i], ID_WIDTH'(i + 8), (i % 2) == 0);
            applyStimulus(0, 0, 0, 0, 1);
         end
      end
      repeat (3) applyStimulus(0, 0, 0, 0, 1);
      checkOutput("drained_2", sb.size(), 0);

      // Randomized traffic with one reset in the middle
      for (int c = 0; c < 400; c++) begin
         logic [4:0] rd;
         rd = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         if (c == 200) doReset();
         applyStimulus(($urandom % 10) < 6, $urandom, rd, ID_WIDTH'($urandom), $urandom % 2);
      end
      repeat (DEPTH + 2) applyStimulus(0, 0, 0, 0, 1);
      checkOutput("drained_final", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
